// File: rtl/start_stop_pkg.sv
// Shared run-state encoding for the front-panel controller and the counter-side bench.
package start_stop_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        HALT    = 2'b10,
        ILLEGAL = 2'b11
    } run_state_t;
endpackage

// File: rtl/start_stop_ctrl_if.sv
// Front-panel bundle: raw buttons in, clean counter commands and status out.
interface start_stop_ctrl_if;
    import start_stop_pkg::*;

    logic               btn_start;
    logic               btn_stop;
    logic               btn_clear;
    logic               start;
    logic               stop;
    logic               clr;
    logic               running;
    logic [STATE_W-1:0] state;

    modport master (
        output btn_start, btn_stop, btn_clear,
        input  start, stop, clr, running, state
    );

    modport slave (
        input  btn_start, btn_stop, btn_clear,
        output start, stop, clr, running, state
    );
endinterface

// File: rtl/button_debounce.sv
// One pushbutton: 2-flop synchroniser, stability-count debouncer, rising-edge detector.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_reg;
    logic             s2_reg;
    logic             db_reg;
    logic             db_d_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            db_reg   <= 1'b0;
            db_d_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            s1_reg   <= btn;
            s2_reg   <= s1_reg;
            db_d_reg <= db_reg;
            // Any return to the accepted level restarts the stability count.
            if (s2_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                db_reg  <= s2_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign level = db_reg;
    assign press = db_reg & ~db_d_reg;
endmodule

// File: rtl/start_stop_ctrl.sv
// Run-state machine turning debounced button presses into single-cycle counter commands.
module start_stop_ctrl
    import start_stop_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    start_stop_ctrl_if.slave  panel
);
    localparam int N_BTN   = 3;
    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_CLEAR = 2;

    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] press;
    logic [N_BTN-1:0] level_unused;

    assign btn_raw = {panel.btn_clear, panel.btn_stop, panel.btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk   (clk),
                .reset (reset),
                .btn   (btn_raw[gi]),
                .level (level_unused[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    run_state_t state_reg, state_next;
    logic       start_reg, start_next;
    logic       stop_reg, stop_next;
    logic       clr_reg, clr_next;
    logic       running_reg, running_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, HALT: if (press[B_START]) state_next = RUN;
            RUN:        if (press[B_STOP])  state_next = HALT;
            default:    state_next = IDLE;
        endcase
        if (press[B_CLEAR]) state_next = IDLE;
    end

    // Start is honoured only outside RUN and stop only inside RUN, so the two never collide.
    always_comb begin
        clr_next     = press[B_CLEAR];
        stop_next    = !press[B_CLEAR] && press[B_STOP] && (state_reg == RUN);
        start_next   = !press[B_CLEAR] && press[B_START]
                       && ((state_reg == IDLE) || (state_reg == HALT));
        running_next = (state_next == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_reg   <= 1'b0;
            stop_reg    <= 1'b0;
            clr_reg     <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            start_reg   <= start_next;
            stop_reg    <= stop_next;
            clr_reg     <= clr_next;
            running_reg <= running_next;
        end
    end

    assign panel.start   = start_reg;
    assign panel.stop    = stop_reg;
    assign panel.clr     = clr_reg;
    assign panel.running = running_reg;
    assign panel.state   = state_reg;
endmodule

// File: tb/tb_start_stop_ctrl.sv
// Bench for start_stop_ctrl: directed panel scenarios plus random button/reset traffic vs. a window model.
module tb_start_stop_ctrl;
    import start_stop_pkg::*;

    localparam int D = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n_start;
    int   n_stop;
    int   n_clr;

    start_stop_ctrl_if panel ();

    start_stop_ctrl #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .panel (panel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronised samples all disagree with it.
    bit          s1_m [3];
    bit          s2_m [3];
    bit          db_m [3];
    bit          dbd_m[3];
    int unsigned win_m[3];
    run_state_t  st_m;
    bit          e_start, e_stop, e_clr;

    task automatic model_step(input bit [2:0] raw, input bit in_reset);
        bit          pr[3];
        bit          s2_pre;
        int unsigned mask;
        mask = (1 << D) - 1;
        if (in_reset) begin
            for (int b = 0; b < 3; b++) begin
                s1_m[b] = 0; s2_m[b] = 0; db_m[b] = 0; dbd_m[b] = 0; win_m[b] = 0;
            end
            st_m = IDLE; e_start = 0; e_stop = 0; e_clr = 0;
            return;
        end
        for (int b = 0; b < 3; b++) pr[b] = db_m[b] && !dbd_m[b];
        e_start = 0; e_stop = 0; e_clr = 0;
        if (pr[2]) begin
            st_m = IDLE; e_clr = 1;
        end else if (pr[1] && st_m == RUN) begin
            st_m = HALT; e_stop = 1;
        end else if (pr[0] && st_m != RUN) begin
            st_m = RUN; e_start = 1;
        end
        for (int b = 0; b < 3; b++) begin
            s2_pre   = s2_m[b];
            dbd_m[b] = db_m[b];
            win_m[b] = ((win_m[b] << 1) | int'(s2_pre)) & mask;
            if (!db_m[b] && win_m[b] == mask) db_m[b] = 1;
            else if (db_m[b] && win_m[b] == 0) db_m[b] = 0;
            s2_m[b] = s1_m[b];
            s1_m[b] = raw[b];
        end
    endtask

    always @(posedge clk) begin
        model_step({panel.btn_clear, panel.btn_stop, panel.btn_start}, !reset);
        #1;
        check_value("m_start", panel.start, e_start);
        check_value("m_stop", panel.stop, e_stop);
        check_value("m_clr", panel.clr, e_clr);
        check_value("m_running", panel.running, (st_m == RUN));
        check_value("m_state", panel.state, st_m);
        check_value("one_hot", panel.start + panel.stop + panel.clr <= 1, 1);
        n_start += panel.start;
        n_stop  += panel.stop;
        n_clr   += panel.clr;
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int which, input int len);
        @(negedge clk);
        if (which == 0) panel.btn_start = 1'b1;
        if (which == 1) panel.btn_stop  = 1'b1;
        if (which == 2) panel.btn_clear = 1'b1;
        idle_cycles(len);
        panel.btn_start = 1'b0;
        panel.btn_stop  = 1'b0;
        panel.btn_clear = 1'b0;
        idle_cycles(12);
    endtask

    task automatic check_quiet(input string tag, input logic [1:0] st);
        check_value({tag, "_start"}, panel.start, 0);
        check_value({tag, "_stop"}, panel.stop, 0);
        check_value({tag, "_clr"}, panel.clr, 0);
        check_value({tag, "_run"}, panel.running, 0);
        check_value({tag, "_state"}, panel.state, st);
    endtask

    task automatic pulse_window(input string tag, input int n);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #2;
            check_value(tag, panel.start, (e == 7));
        end
    endtask

    int s0, p0, c0;
    bit rb[3];

    initial begin
        n_checks = 0; n_errors = 0; n_start = 0; n_stop = 0; n_clr = 0;
        reset = 1'b0;
        panel.btn_start = 1'b0;
        panel.btn_stop  = 1'b0;
        panel.btn_clear = 1'b0;
        idle_cycles(3);
        check_quiet("rst", IDLE);

        // Held start: pulse only after edge 7, never repeated while held.
        @(negedge clk);
        reset = 1'b1;
        panel.btn_start = 1'b1;
        pulse_window("held_start", 20);
        check_value("held_state", panel.state, RUN);
        check_value("held_running", panel.running, 1);
        @(negedge clk);
        panel.btn_start = 1'b0;
        idle_cycles(10);

        p0 = n_stop;
        press_btn(1, 3);
        check_value("glitch_stop_cnt", n_stop - p0, 0);
        check_value("glitch_state", panel.state, RUN);
        press_btn(1, 4);
        check_value("stop_cnt", n_stop - p0, 1);
        check_value("stop_state", panel.state, HALT);

        s0 = n_start;
        press_btn(0, 6);
        check_value("halt_start_cnt", n_start - s0, 1);
        check_value("halt_start_state", panel.state, RUN);

        press_btn(2, 6);
        check_value("clear_state", panel.state, IDLE);
        p0 = n_stop;
        press_btn(1, 6);
        check_value("idle_stop_cnt", n_stop - p0, 0);
        check_value("idle_stop_state", panel.state, IDLE);

        // All three buttons rise together while running.
        press_btn(0, 6);
        s0 = n_start; p0 = n_stop; c0 = n_clr;
        @(negedge clk);
        panel.btn_start = 1'b1; panel.btn_stop = 1'b1; panel.btn_clear = 1'b1;
        idle_cycles(6);
        panel.btn_start = 1'b0; panel.btn_stop = 1'b0; panel.btn_clear = 1'b0;
        idle_cycles(12);
        check_value("simul_clr", n_clr - c0, 1);
        check_value("simul_stop", n_stop - p0, 0);
        check_value("simul_start", n_start - s0, 0);
        check_value("simul_state", panel.state, IDLE);

        // Bouncing start, then stable high.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            panel.btn_start = (i % 2 == 0);
        end
        @(negedge clk);
        panel.btn_start = 1'b1;
        pulse_window("bounce", 15);
        check_value("bounce_state", panel.state, RUN);

        // Reset mid-debounce while running, button held across release.
        @(negedge clk);
        panel.btn_start = 1'b0;
        idle_cycles(12);
        @(negedge clk);
        panel.btn_start = 1'b1;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_quiet("arst_db", IDLE);
        idle_cycles(2);
        reset = 1'b1;
        pulse_window("rel_db", 7);
        #1 reset = 1'b0;
        #1 check_quiet("arst_pulse", IDLE);
        idle_cycles(2);
        reset = 1'b1;
        pulse_window("rel_pulse", 12);
        @(negedge clk);
        panel.btn_start = 1'b0;
        idle_cycles(12);

        rb[0] = 0; rb[1] = 0; rb[2] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
            panel.btn_start = rb[0];
            panel.btn_stop  = rb[1];
            panel.btn_clear = rb[2];
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                idle_cycles($urandom_range(1, 3));
                reset = 1'b1;
            end
        end
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/start_stop_ctrl.md
# start_stop_ctrl

Front-panel control stage that sits directly upstream of the 4-bit start/stop counter. It synchronises and debounces three raw pushbuttons (start, stop, clear). A small run-state machine then turns them into clean single-cycle `start`, `stop` and `clr` pulses that drive the counter's `start`, `stop` and `reset` inputs. It guarantees that the counter never sees a bouncing, metastable or contradictory command.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a synchronised button level is accepted; legal range ≥1.
- `clk`  in  1  single system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_start`  in  1  raw start button, asynchronous to `clk`, active-high.
- `btn_stop`  in  1  raw stop button, asynchronous, active-high.
- `btn_clear`  in  1  raw clear button, asynchronous, active-high.
- `start`  out  1  one-cycle pulse to counter `start`.
- `stop`  out  1  one-cycle pulse to counter `stop`.
- `clr`  out  1  one-cycle pulse, ORed with the system reset to form the counter's active-high `reset`.
- `running`  out  1  high while the FSM is in RUN.
- `state`  out  2  current FSM state encoding, for status LEDs.

## Operation
- Per button, in order:
  - 2-flop synchroniser (`s1`, `s2`).
  - Debouncer holding level `db`, with counter `cnt`.
  - Rising-edge detector (`db_d` register); `press = db & ~db_d`.
- Debounce rule, evaluated each edge:
  - If `s2 == db`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Any `s2` excursion shorter than `DEBOUNCE_CYCLES` cycles is discarded. A release is debounced identically, and releases generate no event.
- FSM states: IDLE=2'b00, RUN=2'b01, HALT=2'b10. 2'b11 is illegal and recovers to IDLE with no pulse.
- Transitions:
  - IDLE or HALT, start press → RUN; pulse `start`.
  - RUN, stop press → HALT; pulse `stop`.
  - Any state, clear press → IDLE; pulse `clr`.
  - Start press in RUN is ignored. Stop press in IDLE or HALT is ignored; no pulse.
- Simultaneous presses in the same cycle: clear > stop > start. At most one of `start`/`stop`/`clr` is ever high in a cycle.
- All outputs are registered. Pulses are exactly one cycle wide regardless of how long the button is held; re-arming requires a debounced release.

## Timing
- Reset (`reset`=0, asynchronous) forces:
  - `start=stop=clr=0`, `running=0`, `state=IDLE`.
  - All `s1`, `s2`, `db`, `db_d` = 0; all `cnt` = 0.
- Release of reset is synchronous in effect. The first active edge after deassertion evaluates normally.
- Latency: a button set high before edge 1 and held stable gives:
  - `s2` high after edge 2.
  - `db` high after edge 2+`DEBOUNCE_CYCLES`.
  - Output pulse high after edge 3+`DEBOUNCE_CYCLES`, for one cycle.
  - With the default this is edge 7.
- A button held through reset release is treated as a fresh press, after the same latency.
- Reset asserted mid-debounce or mid-pulse aborts immediately; no pulse is emitted after reset is released unless the button is still held.

## Structure
- Package `start_stop_pkg`: state typedef/localparams (IDLE, RUN, HALT) and the state width constant. The counter-side testbench shares these.
- Sub-module `button_debounce` (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `btn`, `level`, `press`): holds the synchroniser, debouncer and edge detector. It is instantiated three times.
- Top level holds only the FSM, the priority logic and the output registers.

## Test plan
- Reset, then `btn_start` high and held 20 cycles (D=4) → `start` high exactly during the cycle after edge 7, `state`=RUN, `running`=1; no second pulse while held.
- In RUN, `btn_stop` glitch of 3 cycles → no `stop`, state stays RUN. A 4-cycle-stable press → one `stop` pulse, state=HALT.
- In HALT, a start press → `start` pulse, RUN. In IDLE, a stop press → no pulse, state stays IDLE.
- `btn_start`, `btn_stop` and `btn_clear` rising on the same cycle while in RUN → only `clr` pulses, state=IDLE.
- Bouncing input (toggle every cycle for 10 cycles, then stable high) → exactly one pulse, at 3+4 edges after the final transition.
- `reset` asserted for 2 cycles mid-debounce and again mid-pulse → all outputs 0 asynchronously; with the button held across release, a single pulse follows 7 edges after release.
